// File: rtl/rom_loader_pkg.sv
// Shared types and defaults for the ROM loader: FSM state encoding, download
// index constants and the byte-enable helper used when packing bytes into words.
package loader_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } load_state_e;

    localparam logic [7:0] ROM_INDEX_DEF    = 8'd0;
    localparam logic [7:0] DIP_INDEX_DEF    = 8'd254;
    localparam int         RESET_CYCLES_DEF = 65535;

    // Odd byte addresses land in the upper byte lane of the 16-bit word.
    function automatic logic [1:0] byte_en(input logic a0);
        return {a0, ~a0};
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// HPS download bus and SDRAM write-port signals seen by the ROM loader.
// master = host/SDRAM side, slave = the loader itself.
interface rom_loader_if;

    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    logic        sdr_req;
    logic        sdr_ack;
    logic [22:0] sdr_a;
    logic [1:0]  sdr_ds;
    logic [15:0] sdr_d;
    logic        sdr_we;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
        input  ioctl_wait, sdr_req, sdr_a, sdr_ds, sdr_d, sdr_we
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
        output ioctl_wait, sdr_req, sdr_a, sdr_ds, sdr_d, sdr_we
    );

endinterface

// File: rtl/rom_loader_reset_stretch.sv
// Core reset stretcher: reloads while i_load is high, otherwise counts down to
// zero and holds; o_core_reset is the registered "counter non-zero" flag.
module reset_stretch #(
    parameter int RESET_CYCLES = 65535
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic i_load,
    output logic o_core_reset
);

    localparam int            CW       = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] ZERO     = CW'(0);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          r_core_reset;

    // Counter and its registered non-zero flag.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_cnt        <= LOAD_VAL;
            r_core_reset <= 1'b1;
        end else begin
            if (i_load) begin
                r_cnt <= LOAD_VAL;
            end else if (r_cnt != ZERO) begin
                r_cnt <= r_cnt - ONE;
            end else begin
                r_cnt <= ZERO;
            end
            r_core_reset <= (r_cnt != ZERO);
        end
    end

    assign o_core_reset = r_core_reset;

endmodule

// File: rtl/rom_loader.sv
// Streams HPS ROM download bytes into the SDRAM write port with a toggle
// handshake, captures DIP bytes, and holds the core in reset until a ROM is loaded.
module rom_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX    = ROM_INDEX_DEF,
    parameter logic [7:0] DIP_INDEX    = DIP_INDEX_DEF,
    parameter int         RESET_CYCLES = RESET_CYCLES_DEF
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        user_reset,
    rom_loader_if.slave ldr,
    output logic [7:0]  dip_sw0,
    output logic [7:0]  dip_sw1,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        overrun
);

    load_state_e r_state;
    load_state_e w_state_nxt;

    logic        r_wr_prev;
    logic        r_dl_prev;
    logic        r_wait;
    logic        r_req;
    logic [22:0] r_sdr_a;
    logic [1:0]  r_sdr_ds;
    logic [15:0] r_sdr_d;
    logic [7:0]  r_dip0;
    logic [7:0]  r_dip1;
    logic        r_accepted;
    logic        r_load_pend;
    logic        r_rom_loaded;
    logic        r_overrun;

    logic w_wr_edge;
    logic w_rom_sel;
    logic w_rom_wr;
    logic w_dip_wr;
    logic w_dl_rise;
    logic w_dl_fall;
    logic w_load_req;
    logic w_load_now;
    logic w_accept;
    logic w_drop;
    logic w_wait_nxt;
    logic w_stretch_load;

    assign w_wr_edge  = ldr.ioctl_wr & ~r_wr_prev;
    assign w_rom_sel  = ldr.ioctl_download & (ldr.ioctl_index == ROM_INDEX);
    assign w_rom_wr   = w_wr_edge & w_rom_sel & ~ldr.ioctl_addr[24];
    assign w_dip_wr   = w_wr_edge & (ldr.ioctl_index == DIP_INDEX)
                        & (ldr.ioctl_addr[24:1] == 24'd0);
    assign w_dl_rise  = ldr.ioctl_download & ~r_dl_prev;
    assign w_dl_fall  = ~ldr.ioctl_download & r_dl_prev;
    // A load seen while a transfer is still in flight is parked until the FSM is idle.
    assign w_load_req = (w_dl_fall & (ldr.ioctl_index == ROM_INDEX) & r_accepted) | r_load_pend;
    assign w_load_now = w_load_req & (r_state == IDLE);

    // FSM state register.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: leave WAIT once the acknowledge toggle catches up.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_rom_wr) w_state_nxt = WAIT;
                else          w_state_nxt = IDLE;
            end
            WAIT: begin
                if (ldr.sdr_ack == r_req) w_state_nxt = IDLE;
                else                      w_state_nxt = WAIT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: accept or drop ROM bytes; hold wait one cycle past the return to IDLE.
    always_comb begin
        w_accept   = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = w_rom_wr;
                w_drop   = 1'b0;
            end
            WAIT: begin
                w_accept = 1'b0;
                w_drop   = w_rom_wr;
            end
            default: begin
                w_accept = 1'b0;
                w_drop   = 1'b0;
            end
        endcase
        w_wait_nxt = (r_state == WAIT) | (w_state_nxt == WAIT);
    end

    // Datapath, DIP capture, session tracking and sticky status flags.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_wr_prev    <= 1'b0;
            r_dl_prev    <= 1'b0;
            r_wait       <= 1'b0;
            r_req        <= 1'b0;
            r_sdr_a      <= 23'd0;
            r_sdr_ds     <= 2'd0;
            r_sdr_d      <= 16'd0;
            r_dip0       <= 8'hFF;
            r_dip1       <= 8'hFF;
            r_accepted   <= 1'b0;
            r_load_pend  <= 1'b0;
            r_rom_loaded <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_wr_prev <= ldr.ioctl_wr;
            r_dl_prev <= ldr.ioctl_download;
            r_wait    <= w_wait_nxt;

            if (w_accept) begin
                r_sdr_a  <= ldr.ioctl_addr[23:1];
                r_sdr_ds <= byte_en(ldr.ioctl_addr[0]);
                r_sdr_d  <= {ldr.ioctl_dout, ldr.ioctl_dout};
                r_req    <= ~r_req;
            end else begin
                r_req    <= r_req;
            end

            if (w_drop) r_overrun <= 1'b1;
            else        r_overrun <= r_overrun;

            if (w_dip_wr && ldr.ioctl_addr[0]) begin
                r_dip1 <= ldr.ioctl_dout;
            end else if (w_dip_wr) begin
                r_dip0 <= ldr.ioctl_dout;
            end else begin
                r_dip0 <= r_dip0;
            end

            // A new session forgets earlier bytes unless one arrives on that very edge.
            if (w_accept)       r_accepted <= 1'b1;
            else if (w_dl_rise) r_accepted <= 1'b0;
            else                r_accepted <= r_accepted;

            if (w_load_now)      r_load_pend <= 1'b0;
            else if (w_load_req) r_load_pend <= 1'b1;
            else                 r_load_pend <= r_load_pend;

            if (w_load_now) r_rom_loaded <= 1'b1;
            else            r_rom_loaded <= r_rom_loaded;
        end
    end

    assign w_stretch_load = user_reset | ~r_rom_loaded | w_rom_sel;

    reset_stretch #(
        .RESET_CYCLES (RESET_CYCLES)
    ) u_reset_stretch (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .i_load       (w_stretch_load),
        .o_core_reset (core_reset)
    );

    assign ldr.ioctl_wait = r_wait;
    assign ldr.sdr_req    = r_req;
    assign ldr.sdr_a      = r_sdr_a;
    assign ldr.sdr_ds     = r_sdr_ds;
    assign ldr.sdr_d      = r_sdr_d;
    assign ldr.sdr_we     = w_rom_sel;
    assign dip_sw0        = r_dip0;
    assign dip_sw1        = r_dip1;
    assign rom_loaded     = r_rom_loaded;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a transaction-level reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_rom_loader;

    localparam int RC = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       user_reset;
    logic [7:0] dip_sw0, dip_sw1;
    logic       rom_loaded, core_reset, overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_delay = 1;

    rom_loader_if ifc ();

    rom_loader #(
        .ROM_INDEX    (8'd0),
        .DIP_INDEX    (8'd254),
        .RESET_CYCLES (RC)
    ) dut (
        .clk_sys    (clk),
        .rst_n      (rst_n),
        .user_reset (user_reset),
        .ldr        (ifc.slave),
        .dip_sw0    (dip_sw0),
        .dip_sw1    (dip_sw1),
        .rom_loaded (rom_loaded),
        .core_reset (core_reset),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding transfer, byte count per session, integer reset timer.
    logic        m_valid = 1'b0;
    logic        m_wr_prev, m_dl_prev, m_busy, m_pend, m_loaded, m_ovr, m_req, m_wait, m_core;
    logic [22:0] m_a;
    logic [1:0]  m_ds;
    logic [15:0] m_d;
    logic [7:0]  m_dip0, m_dip1;
    int          m_bytes, m_cnt;

    always @(posedge clk) begin
        logic wr_edge, rom_hit, dip_hit, was_busy, rom_sel;
        rom_sel = ifc.ioctl_download && (ifc.ioctl_index == 8'd0);
        if (!rst_n) begin
            m_wr_prev = 1'b0; m_dl_prev = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
            m_loaded = 1'b0; m_ovr = 1'b0; m_req = 1'b0; m_wait = 1'b0;
            m_a = 23'd0; m_ds = 2'd0; m_d = 16'd0; m_dip0 = 8'hFF; m_dip1 = 8'hFF;
            m_bytes = 0; m_cnt = RC; m_core = 1'b1; m_valid = 1'b1;
        end else begin
            wr_edge  = ifc.ioctl_wr && !m_wr_prev;
            rom_hit  = wr_edge && rom_sel && !ifc.ioctl_addr[24];
            dip_hit  = wr_edge && (ifc.ioctl_index == 8'd254) && ((ifc.ioctl_addr >> 1) == 25'd0);
            was_busy = m_busy;
            if (!m_dl_prev && ifc.ioctl_download) m_bytes = 0;
            if (was_busy) begin
                if (rom_hit) m_ovr = 1'b1;
                if (ifc.sdr_ack == m_req) m_busy = 1'b0;
            end else if (rom_hit) begin
                m_a = ifc.ioctl_addr[23:1];
                m_ds = ifc.ioctl_addr[0] ? 2'b10 : 2'b01;
                m_d = {ifc.ioctl_dout, ifc.ioctl_dout};
                m_req = !m_req;
                m_busy = 1'b1;
                m_bytes++;
            end
            m_wait = was_busy || m_busy;
            if (dip_hit && ifc.ioctl_addr[0]) m_dip1 = ifc.ioctl_dout;
            else if (dip_hit) m_dip0 = ifc.ioctl_dout;
            if (m_dl_prev && !ifc.ioctl_download && ifc.ioctl_index == 8'd0 && m_bytes > 0) m_pend = 1'b1;
            m_core = (m_cnt != 0);
            if (user_reset || !m_loaded || rom_sel) m_cnt = RC;
            else if (m_cnt > 0) m_cnt--;
            if (m_pend && !was_busy) begin
                m_loaded = 1'b1;
                m_pend = 1'b0;
            end
            m_wr_prev = ifc.ioctl_wr;
            m_dl_prev = ifc.ioctl_download;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_ioctl_wait", ifc.ioctl_wait, m_wait);
            chk("cyc_sdr_req",    ifc.sdr_req,    m_req);
            chk("cyc_sdr_a",      ifc.sdr_a,      m_a);
            chk("cyc_sdr_ds",     ifc.sdr_ds,     m_ds);
            chk("cyc_sdr_d",      ifc.sdr_d,      m_d);
            chk("cyc_sdr_we",     ifc.sdr_we,     ifc.ioctl_download && ifc.ioctl_index == 8'd0);
            chk("cyc_dip_sw0",    dip_sw0,        m_dip0);
            chk("cyc_dip_sw1",    dip_sw1,        m_dip1);
            chk("cyc_rom_loaded", rom_loaded,     m_loaded);
            chk("cyc_overrun",    overrun,        m_ovr);
            chk("cyc_core_reset", core_reset,     m_core);
        end
    end

    // SDRAM side: returns the acknowledge toggle ack_delay negedges after a request.
    initial begin
        int pend_cnt = 0;
        ifc.sdr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.sdr_req !== ifc.sdr_ack) begin
                pend_cnt++;
                if (pend_cnt >= ack_delay) begin
                    ifc.sdr_ack = ifc.sdr_req;
                    pend_cnt = 0;
                end
            end else begin
                pend_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        ifc.ioctl_addr = a;
        ifc.ioctl_dout = d;
        ifc.ioctl_wr = 1'b1;
        tick();
        ifc.ioctl_wr = 1'b0;
    endtask

    task automatic run_window(input int n, output int wc, output int tg);
        logic p;
        wc = 0;
        tg = 0;
        p = ifc.sdr_req;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ifc.ioctl_wait) wc++;
            if (ifc.sdr_req !== p) tg++;
            p = ifc.sdr_req;
        end
    endtask

    initial begin
        int   wc, tg, k;
        logic r0;
        rst_n = 1'b0; user_reset = 1'b0;
        ifc.ioctl_download = 1'b0; ifc.ioctl_index = 8'd0; ifc.ioctl_wr = 1'b0;
        ifc.ioctl_addr = 25'd0; ifc.ioctl_dout = 8'd0;
        repeat (3) tick();
        chk("rst_core_reset", core_reset, 1'b1);
        chk("rst_dip_sw0", dip_sw0, 8'hFF);
        chk("rst_dip_sw1", dip_sw1, 8'hFF);
        chk("rst_rom_loaded", rom_loaded, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_wait", ifc.ioctl_wait, 1'b0);
        chk("rst_sdr_req", ifc.sdr_req, 1'b0);
        rst_n = 1'b1;
        tick();

        // DIP bytes; address 2 must be ignored and no SDRAM request may appear.
        ifc.ioctl_download = 1'b1; ifc.ioctl_index = 8'd254;
        tick();
        send(25'd0, 8'h3C); tick();
        send(25'd1, 8'hC3); tick();
        send(25'd2, 8'h77); tick();
        chk("dip_sw0", dip_sw0, 8'h3C);
        chk("dip_sw1", dip_sw1, 8'hC3);
        chk("dip_no_req", ifc.sdr_req, 1'b0);
        chk("dip_we", ifc.sdr_we, 1'b0);
        ifc.ioctl_download = 1'b0;
        tick();

        // Session with no accepted byte (only an addr[24]=1 write).
        ifc.ioctl_download = 1'b1; ifc.ioctl_index = 8'd0;
        tick();
        chk("rom_we", ifc.sdr_we, 1'b1);
        send(25'h1000010, 8'h55);
        chk("hi_addr_no_wait", ifc.ioctl_wait, 1'b0);
        tick();
        chk("hi_addr_no_req", ifc.sdr_req, 1'b0);
        ifc.ioctl_download = 1'b0;
        repeat (20) tick();
        chk("empty_rom_loaded", rom_loaded, 1'b0);
        chk("empty_core_reset", core_reset, 1'b1);

        // Single ROM byte at 0x000003, acknowledge after 3 cycles.
        ifc.ioctl_download = 1'b1;
        tick();
        ack_delay = 3;
        r0 = ifc.sdr_req;
        send(25'h000003, 8'hA5);
        chk("b1_sdr_a", ifc.sdr_a, 23'd1);
        chk("b1_sdr_ds", ifc.sdr_ds, 2'b10);
        chk("b1_sdr_d", ifc.sdr_d, 16'hA5A5);
        chk("b1_model_d", m_d, 16'hA5A5);
        run_window(10, wc, tg);
        chk("b1_wait_cycles", ((ifc.sdr_req !== r0) ? 0 : 0) + 1 + wc, 4);
        chk("b1_toggles", tg + 1, 1);
        chk("b1_req_now", ifc.sdr_req, 1'b1);

        // Second edge while waiting is dropped and flagged.
        r0 = ifc.sdr_req;
        send(25'h000004, 8'h11);
        tick();
        send(25'h000005, 8'h22);
        run_window(10, wc, tg);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_model_flag", m_ovr, 1'b1);
        chk("ovr_sdr_d", ifc.sdr_d, 16'h1111);
        chk("ovr_sdr_a", ifc.sdr_a, 23'd2);
        chk("ovr_sdr_ds", ifc.sdr_ds, 2'b01);
        chk("ovr_one_toggle", ifc.sdr_req != r0, 1'b1);

        // DIP byte accepted while the FSM waits on a ROM byte.
        ack_delay = 4;
        send(25'h000006, 8'h5A);
        ifc.ioctl_index = 8'd254;
        tick();
        send(25'd1, 8'h99);
        chk("dip_in_wait_val", dip_sw1, 8'h99);
        chk("dip_in_wait_busy", ifc.ioctl_wait, 1'b1);
        ifc.ioctl_index = 8'd0;
        run_window(10, wc, tg);

        // Fastest handshake: wait high for exactly two cycles.
        ack_delay = 1;
        send(25'h000007, 8'h3F);
        run_window(6, wc, tg);
        chk("min_wait_cycles", 1 + wc, 2);
        chk("min_sdr_d", ifc.sdr_d, 16'h3F3F);

        // End of 4-byte session: rom_loaded next cycle, core_reset clears 17 cycles later.
        chk("pre_load_core_reset", core_reset, 1'b1);
        ifc.ioctl_download = 1'b0;
        tick();
        chk("loaded_next_cycle", rom_loaded, 1'b1);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            k++;
            if (core_reset == 1'b0) break;
        end
        chk("core_reset_release", k, 17);

        // User reset pulse after load.
        repeat (3) tick();
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        tick();
        chk("user_reset_fast", core_reset, 1'b1);
        k = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            k++;
            if (core_reset == 1'b0) break;
        end
        chk("user_reset_hold", k, RC + 1);

        // Reset in the middle of a transfer abandons it.
        ifc.ioctl_download = 1'b1;
        tick();
        ack_delay = 50;
        send(25'h000008, 8'hEE);
        chk("abandon_wait_hi", ifc.ioctl_wait, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("abandon_wait", ifc.ioctl_wait, 1'b0);
        chk("abandon_req", ifc.sdr_req, 1'b0);
        chk("abandon_loaded", rom_loaded, 1'b0);
        chk("abandon_core_reset", core_reset, 1'b1);
        rst_n = 1'b1;
        ack_delay = 1;
        tick();
        send(25'h000002, 8'h42);
        chk("restart_req", ifc.sdr_req, 1'b1);
        chk("restart_sdr_a", ifc.sdr_a, 23'd1);
        run_window(5, wc, tg);
        chk("restart_idle", ifc.ioctl_wait, 1'b0);
        ifc.ioctl_download = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
